// File: rtl/im_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : im_stream_loader
//  Description : Receives a framed byte stream (16-bit word count, 4*N
//                instruction bytes MSB first, XOR checksum byte), packs the
//                bytes into 32-bit words, writes them into the instruction
//                memory and holds the CPU until a good image has loaded.
//  Revision    : 1.0  initial release
// ============================================================================
module im_stream_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Word count and word index share one 11-bit width so the last-word
    // compare is a plain equality against N-1.
    localparam int          c_N_W = 11;
    localparam logic [15:0] c_MAX = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_hdr_hi;
    logic [c_N_W-1:0] r_n;
    logic [c_N_W-1:0] r_idx;
    logic [1:0]       r_lane;
    logic [23:0]      r_shift;
    logic [7:0]       r_xor;
    logic             r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]      r_wdata;

    logic             w_ready;
    logic             w_accept;
    logic             w_restart;
    logic [15:0]      w_hdr;
    logic             w_hdr_bad;
    logic             w_last_word;

    assign w_ready     = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) ||
                         (r_state == S_DATA)   || (r_state == S_CHECK);
    assign w_accept    = byte_valid & w_ready;
    // start is only honoured outside a frame.
    assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
    assign w_hdr       = {r_hdr_hi, byte_in};
    assign w_hdr_bad   = (w_hdr == 16'd0) || (w_hdr > c_MAX);
    assign w_last_word = (r_idx == (r_n - 11'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; every transition other than a restart needs an accepted byte.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (w_accept) w_next = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (w_accept) w_next = w_hdr_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (w_accept && (r_lane == 2'd3) && w_last_word) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) w_next = (byte_in == r_xor) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Header capture, byte packing, checksum accumulation and the registered write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hdr_hi <= 8'd0;
            r_n      <= '0;
            r_idx    <= '0;
            r_lane   <= 2'd0;
            r_shift  <= 24'd0;
            r_xor    <= 8'd0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_idx  <= '0;
                r_lane <= 2'd0;
                r_xor  <= 8'd0;
            end
            if (w_accept) begin
                case (r_state)
                    S_HDR_HI: r_hdr_hi <= byte_in;
                    S_HDR_LO: r_n      <= w_hdr[c_N_W-1:0];
                    S_DATA: begin
                        r_xor <= r_xor ^ byte_in;
                        if (r_lane == 2'd3) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_idx[ADDR_W-1:0];
                            r_wdata <= {r_shift, byte_in};
                            r_lane  <= 2'd0;
                            r_idx   <= r_idx + 11'd1;
                        end else begin
                            r_shift <= {r_shift[15:0], byte_in};
                            r_lane  <= r_lane + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_ready = w_ready;
    assign busy       = w_ready;
    assign cpu_hold   = (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign im_we      = r_we;
    assign im_waddr   = r_waddr;
    assign im_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_im_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_im_stream_loader
//  Description : Self-checking bench for im_stream_loader: a per-cycle vector
//                table for the simple frames, plus hand sequences for
//                stalled streams, mid-frame reset and start-while-busy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_im_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [9:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    logic [7:0]  fr[$];

    typedef struct {
        logic        rst, st, vld;
        logic [7:0]  b;
        logic        rdy, we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        bsy, hold, dn, err;
    } vec_t;

    vec_t tbl[$];

    im_stream_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .im_we(im_we),
        .im_waddr(im_waddr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write-port monitor: im_we is a single-cycle pulse, so one negedge sees it.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wa.push_back(im_waddr);
            wd.push_back(im_wdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, st, vld, input logic [7:0] b,
                                input logic rdy, we, input logic [9:0] addr,
                                input logic [31:0] data, input logic bsy, hold, dn, err);
        vec_t v;
        v.rst = rst; v.st = st; v.vld = vld; v.b = b;
        v.rdy = rdy; v.we = we; v.addr = addr; v.data = data;
        v.bsy = bsy; v.hold = hold; v.dn = dn; v.err = err;
        return v;
    endfunction

    // Offer one byte until accepted; rnd inserts random bubbles.
    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit st);
        int guard = 0;
        bit acc   = 1'b0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            start      = st;
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in    = byte_valid ? b : 8'($urandom);
            acc        = byte_valid && byte_ready;
            @(posedge clk);
            guard++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input bit rnd);
        foreach (fr[i]) send_byte(fr[i], rnd, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic dn, err, hold, bsy);
        chk({tag, "_done"},  32'(done),     32'(dn));
        chk({tag, "_error"}, 32'(error),    32'(err));
        chk({tag, "_hold"},  32'(cpu_hold), 32'(hold));
        chk({tag, "_busy"},  32'(busy),     32'(bsy));
    endtask

    task automatic chk_writes(input string tag, input int n,
                              input logic [31:0] d0, d1, d2);
        logic [31:0] exp_d[3];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
        chk({tag, "_nwrites"}, 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), wd[i], exp_d[i]);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (2) @(posedge clk);

        // rst st vld byte | rdy we addr data | busy hold done err
        tbl.push_back(mk(0,0,0,8'h00, 0,0,10'd0,32'h0, 0,1,0,0)); // reset state
        tbl.push_back(mk(0,1,1,8'hAA, 0,0,10'd0,32'h0, 0,1,0,0)); // reset beats start
        tbl.push_back(mk(1,0,1,8'h55, 0,0,10'd0,32'h0, 0,1,0,0)); // byte in IDLE ignored
        // Single good word DEADBEEF, checksum 22
        tbl.push_back(mk(1,1,0,8'h00, 1,0,10'd0,32'h0, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h00, 1,0,10'd0,32'h0, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h01, 1,0,10'd0,32'h0, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'hDE, 1,0,10'd0,32'h0, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'hAD, 1,0,10'd0,32'h0, 1,1,0,0));
        tbl.push_back(mk(1,0,0,8'h99, 1,0,10'd0,32'h0, 1,1,0,0)); // bubble
        tbl.push_back(mk(1,0,1,8'hBE, 1,0,10'd0,32'h0, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'hEF, 1,1,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h22, 0,0,10'd0,32'hDEADBEEF, 0,0,1,0));
        tbl.push_back(mk(1,0,1,8'h33, 0,0,10'd0,32'hDEADBEEF, 0,0,1,0)); // DONE holds
        // Header N=0 -> ERR
        tbl.push_back(mk(1,1,0,8'h00, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h00, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h00, 0,0,10'd0,32'hDEADBEEF, 0,1,0,1));
        // Header N=1025 -> ERR
        tbl.push_back(mk(1,1,0,8'h00, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h04, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h01, 0,0,10'd0,32'hDEADBEEF, 0,1,0,1));
        // Word 12345678 with bad checksum FF (correct would be 08)
        tbl.push_back(mk(1,1,0,8'h00, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h00, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h01, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h12, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h34, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h56, 1,0,10'd0,32'hDEADBEEF, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'h78, 1,1,10'd0,32'h12345678, 1,1,0,0));
        tbl.push_back(mk(1,0,1,8'hFF, 0,0,10'd0,32'h12345678, 0,1,0,1));

        foreach (tbl[i]) begin
            @(negedge clk);
            reset      = tbl[i].rst;
            start      = tbl[i].st;
            byte_valid = tbl[i].vld;
            byte_in    = tbl[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(byte_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_we",    i), 32'(im_we),      32'(tbl[i].we));
            chk($sformatf("v%0d_addr",  i), 32'(im_waddr),   32'(tbl[i].addr));
            chk($sformatf("v%0d_data",  i), im_wdata,        tbl[i].data);
            chk($sformatf("v%0d_busy",  i), 32'(busy),       32'(tbl[i].bsy));
            chk($sformatf("v%0d_hold",  i), 32'(cpu_hold),   32'(tbl[i].hold));
            chk($sformatf("v%0d_done",  i), 32'(done),       32'(tbl[i].dn));
            chk($sformatf("v%0d_error", i), 32'(error),      32'(tbl[i].err));
        end
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0;

        // Three words with random valid gaps; checksum 01^02^03 = 00
        wa.delete(); wd.delete();
        do_start();
        fr = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
               8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
        send_frame(1'b1);
        chk_writes("t2", 3, 32'h1, 32'h2, 32'h3);
        chk_status("t2", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset after 6 data bytes of an N=2 frame
        do_start();
        fr = '{8'h00, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        send_frame(1'b0);
        reset = 1'b0; byte_valid = 1'b1; byte_in = 8'h77;
        @(posedge clk);
        #1;
        chk("t5_ready", 32'(byte_ready), 32'd0);
        chk("t5_we",    32'(im_we),      32'd0);
        chk("t5_addr",  32'(im_waddr),   32'd0);
        chk("t5_data",  im_wdata,        32'd0);
        chk_status("t5", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1; byte_valid = 1'b0;
        wa.delete(); wd.delete();
        do_start();
        fr = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_frame(1'b0);
        chk_writes("t5b", 1, 32'hAABBCCDD, 32'h0, 32'h0);
        chk_status("t5b", 1'b1, 1'b0, 1'b0, 1'b0);

        // start pulsed mid-DATA is ignored; checksum of 11223344,55667788 is 88
        wa.delete(); wd.delete();
        do_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b1);
        #1;
        chk("t6_busy_after_start", 32'(busy), 32'd1);
        fr = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_frame(1'b0);
        chk_writes("t6", 2, 32'h11223344, 32'h55667788, 32'h0);
        chk_status("t6", 1'b1, 1'b0, 1'b0, 1'b0);

        // start in DONE clears done and loads a fresh frame; checksum 04
        wa.delete(); wd.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk_status("t6s", 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        fr = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_frame(1'b0);
        chk_writes("t6b", 1, 32'h01020304, 32'h0, 32'h0);
        chk_status("t6b", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
